// File: rtl/switch_input_conditioner_if.sv
// Switch-vector bundle between the raw board switches and the conditioner.
// Latency: none (wires only).
// Backpressure: none; the switch vector and the status outputs are free-running levels.
interface switch_input_conditioner_if #(
    parameter int WIDTH = 15
);
    logic [WIDTH-1:0] SW;       // raw, asynchronous slide switches
    logic [WIDTH-1:0] SW_OUT;   // debounced, registered vector
    logic             CHANGED;  // one-cycle strobe when SW_OUT takes a new value
    logic             STABLE;   // input has matched the candidate for the full window

    // Switch side: drives raw switches, observes the conditioned result.
    modport master (
        output SW,
        input  SW_OUT,
        input  CHANGED,
        input  STABLE
    );

    // Conditioner side: consumes raw switches, produces the conditioned result.
    modport slave (
        input  SW,
        output SW_OUT,
        output CHANGED,
        output STABLE
    );
endinterface

// File: rtl/switch_input_conditioner.sv
// Synchronizes and debounces the slide-switch vector with one shared stability window.
// Latency: DEBOUNCE_CYCLES+3 edges from the first edge sampling a new SW to SW_OUT/CHANGED.
// Backpressure: none; outputs are registered levels/strobes, downstream must sample every cycle.
module switch_input_conditioner #(
    parameter int WIDTH           = 15,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    switch_input_conditioner_if.slave   sw_if
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES-1, where it saturates.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q,   sync1_d;
    logic [WIDTH-1:0] sync2_q,   sync2_d;
    logic [WIDTH-1:0] cand_q,    cand_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] sw_out_q,  sw_out_d;
    logic             changed_q, changed_d;
    logic             stable_q,  stable_d;

    // Next-state: two-flop synchronizer, candidate tracking, saturating window counter, commit.
    always_comb begin
        sync1_d   = sw_if.SW;
        sync2_d   = sync1_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        sw_out_d  = sw_out_q;
        changed_d = 1'b0;
        stable_d  = 1'b0;

        if (sync2_q != cand_q) begin
            // Any bit moving restarts the shared window; a mismatch always beats a commit.
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            // Window complete: hold the counter and commit only a genuinely new value,
            // so an excursion that returns to the committed vector never strobes CHANGED.
            stable_d = 1'b1;
            if (cand_q != sw_out_q) begin
                sw_out_d  = cand_q;
                changed_d = 1'b1;
            end
        end
    end

    // State registers; all clear immediately on RST regardless of CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            sw_out_q  <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            sw_out_q  <= sw_out_d;
            changed_q <= changed_d;
            stable_q  <= stable_d;
        end
    end

    assign sw_if.SW_OUT  = sw_out_q;
    assign sw_if.CHANGED = changed_q;
    assign sw_if.STABLE  = stable_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Bench for the switch conditioner: directed corner sequences, a vector table and random stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_switch_input_conditioner;

    localparam int W = 15;
    localparam int D = 16;

    typedef struct {
        logic [W-1:0] sw;
        int           hold;
        logic [W-1:0] exp_out;
        int           exp_chg;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int tests     = 0;
    int fails     = 0;
    int chg_count = 0;
    bit chk_en    = 1'b1;

    // Reference model state: sync pipeline plus a history of the last D+1 samples seen downstream.
    logic [W-1:0] m_s1, m_s2, m_out;
    logic         m_chg, m_stb;
    logic [W-1:0] hist[$];

    always #5 CLK = ~CLK;

    switch_input_conditioner_if #(.WIDTH(W)) sw_if ();

    switch_input_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .sw_if (sw_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge; count CHANGED strobes seen.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (sw_if.CHANGED) chg_count++;
    endtask

    task automatic mdl_reset();
        m_s1  = '0;
        m_s2  = '0;
        m_out = '0;
        m_chg = 1'b0;
        m_stb = 1'b0;
        hist.delete();
        hist.push_back('0);
    endtask

    // A value commits once D+1 consecutive downstream samples agree.
    task automatic mdl_step(input logic [W-1:0] sw);
        logic [W-1:0] s;
        bit           same;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = sw;
        hist.push_back(s);
        if (hist.size() > D + 1) void'(hist.pop_front());
        same = (hist.size() == D + 1);
        foreach (hist[i]) if (hist[i] != s) same = 1'b0;
        m_stb = same;
        m_chg = same && (s != m_out);
        if (m_chg) m_out = s;
    endtask

    // Continuous model comparison on the falling edge.
    initial begin
        mdl_reset();
        forever begin
            @(posedge CLK);
            if (RST) mdl_reset();
            else     mdl_step(sw_if.SW);
            @(negedge CLK);
            if (RST) mdl_reset();
            if (chk_en) begin
                check("model_sw_out",  32'(sw_if.SW_OUT),  32'(m_out));
                check("model_changed", 32'(sw_if.CHANGED), 32'(m_chg));
                check("model_stable",  32'(sw_if.STABLE),  32'(m_stb));
            end
        end
    end

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] rv;

        vecs[0] = '{15'h0055, 20, 15'h0055, 1};
        vecs[1] = '{15'h0AAA, 16, 15'h0055, 0};
        vecs[2] = '{15'h0055, 25, 15'h0055, 0};
        vecs[3] = '{15'h0AAA, 17, 15'h0055, 0};
        vecs[4] = '{15'h0055, 25, 15'h0055, 2};
        vecs[5] = '{15'h7FFF, 30, 15'h7FFF, 1};
        vecs[6] = '{15'h0000, 19, 15'h0000, 1};
        vecs[7] = '{15'h4001,  1, 15'h0000, 0};

        // Reset held with all switches on
        sw_if.SW = 15'h7FFF;
        repeat (3) tick();
        check("rst_sw_out",  32'(sw_if.SW_OUT),  32'h0);
        check("rst_changed", 32'(sw_if.CHANGED), 32'h0);
        check("rst_stable",  32'(sw_if.STABLE),  32'h0);
        sw_if.SW = '0;
        #2 RST = 1'b0;
        chg_count = 0;
        repeat (15) tick();
        check("t1_stable_edge15", 32'(sw_if.STABLE), 32'h0);
        tick();
        check("t1_stable_edge16", 32'(sw_if.STABLE), 32'h1);
        check("t1_no_changed",    32'(chg_count),    32'h0);

        // Step to 2AA5: commit on edge 19
        repeat (3) tick();
        sw_if.SW  = 15'h2AA5;
        chg_count = 0;
        repeat (18) tick();
        check("t2_out_edge18",    32'(sw_if.SW_OUT), 32'h0);
        check("t2_stable_edge18", 32'(sw_if.STABLE), 32'h0);
        tick();
        check("t2_out_edge19",     32'(sw_if.SW_OUT),  32'h2AA5);
        check("t2_changed_edge19", 32'(sw_if.CHANGED), 32'h1);
        check("t2_stable_edge19",  32'(sw_if.STABLE),  32'h1);
        tick();
        check("t2_changed_edge20", 32'(sw_if.CHANGED), 32'h0);
        check("t2_chg_count",      32'(chg_count),     32'h1);

        // Excursion and return to the committed value
        repeat (2) tick();
        chg_count = 0;
        sw_if.SW  = 15'h7FFF;
        repeat (3) tick();
        check("t3_stable_drop", 32'(sw_if.STABLE), 32'h0);
        repeat (7) tick();
        sw_if.SW = 15'h2AA5;
        repeat (30) tick();
        check("t3_out",       32'(sw_if.SW_OUT), 32'h2AA5);
        check("t3_no_change", 32'(chg_count),    32'h0);
        check("t3_stable",    32'(sw_if.STABLE), 32'h1);

        // Bounce, then hold 0001
        chg_count = 0;
        for (int i = 0; i < 9; i++) begin
            sw_if.SW = (i % 2 != 0) ? 15'h0001 : 15'h0000;
            repeat (3) tick();
        end
        sw_if.SW = 15'h0001;
        repeat (18) tick();
        check("t4_out_edge18", 32'(sw_if.SW_OUT), 32'h2AA5);
        check("t4_no_early",   32'(chg_count),    32'h0);
        tick();
        check("t4_out_edge19",     32'(sw_if.SW_OUT),  32'h0001);
        check("t4_changed_edge19", 32'(sw_if.CHANGED), 32'h1);
        repeat (5) tick();
        check("t4_chg_count", 32'(chg_count),    32'h1);
        check("t4_locked",    32'(sw_if.STABLE), 32'h1);

        // Asynchronous clear while locked on a non-zero value
        #2 RST = 1'b1;
        #1;
        check("async_sw_out", 32'(sw_if.SW_OUT), 32'h0);
        check("async_stable", 32'(sw_if.STABLE), 32'h0);
        sw_if.SW = '0;
        repeat (2) tick();
        #2 RST = 1'b0;

        // Mid-settling reset, then commit 19 edges after release
        repeat (3) tick();
        sw_if.SW = 15'h1234;
        repeat (10) tick();
        #1 RST = 1'b1;
        #1;
        check("t5_rst_out",     32'(sw_if.SW_OUT),  32'h0);
        check("t5_rst_changed", 32'(sw_if.CHANGED), 32'h0);
        check("t5_rst_stable",  32'(sw_if.STABLE),  32'h0);
        repeat (2) tick();
        #2 RST = 1'b0;
        chg_count = 0;
        repeat (18) tick();
        check("t5_out_edge18", 32'(sw_if.SW_OUT), 32'h0);
        check("t5_no_early",   32'(chg_count),    32'h0);
        tick();
        check("t5_out_edge19",     32'(sw_if.SW_OUT),  32'h1234);
        check("t5_changed_edge19", 32'(sw_if.CHANGED), 32'h1);

        // Third value lands at sync2 exactly on the would-be commit edge
        repeat (5) tick();
        sw_if.SW = 15'h0F0F;
        repeat (16) tick();
        sw_if.SW = 15'h7000;
        repeat (2) tick();
        check("t6_out_edge18", 32'(sw_if.SW_OUT), 32'h1234);
        tick();
        check("t6_out_edge19",     32'(sw_if.SW_OUT),  32'h1234);
        check("t6_changed_edge19", 32'(sw_if.CHANGED), 32'h0);
        check("t6_stable_edge19",  32'(sw_if.STABLE),  32'h0);
        repeat (15) tick();
        check("t6_out_edge34", 32'(sw_if.SW_OUT), 32'h1234);
        tick();
        check("t6_out_edge35",     32'(sw_if.SW_OUT),  32'h7000);
        check("t6_changed_edge35", 32'(sw_if.CHANGED), 32'h1);

        // Vector table
        repeat (3) tick();
        for (int v = 0; v < 8; v++) begin
            chg_count = 0;
            sw_if.SW  = vecs[v].sw;
            repeat (vecs[v].hold) tick();
            check($sformatf("vec%0d_out", v), 32'(sw_if.SW_OUT), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_chg", v), 32'(chg_count),    32'(vecs[v].exp_chg));
        end

        // Random segments, then a long hold that must commit
        rv = '0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) rv = W'($urandom);
            sw_if.SW = rv;
            repeat ($urandom_range(1, 22)) tick();
        end
        repeat (25) tick();
        check("rand_final_out",    32'(sw_if.SW_OUT), 32'(rv));
        check("rand_final_stable", 32'(sw_if.STABLE), 32'h1);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
